hex_display_ctrl: RTL and testbench

- Parametrised multi-digit seven-segment display controller with a memory-mapped slave interface.
- Replaces one single-digit segment output port per digit with one block that drives NUM_DIGITS digits.
- Adds an optional hex decode mode, per-digit blink and a selectable output polarity.
- Sits on the system interconnect as a zero-wait-state slave; out_port drives the board HEX pins.

---
 rtl/hex_display_pkg.sv | 38 +++
 rtl/hex7_seg_decode.sv | 16 +
 rtl/hex_display_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the multi-digit seven-segment display controller.
// Register layout helpers, segment bit order and the hex glyph table.
// Pure declarations; no logic, no latency, no flow control.
package hex_display_pkg;

  // CTRL register bit positions
  localparam int CTRL_DECODE_BIT   = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;
  localparam int CTRL_W            = 2;

  // Segment bit order inside a 7-bit digit field: {g,f,e,d,c,b,a}
  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int MAX_DIGITS = 8;

  // Glyphs for 0..F, gfedcba with 1 = lit; element 15 is listed first
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Digit registers occupy offsets 0..nd-1; control registers follow them
  function automatic int ctrl_offset(input int nd);
    return nd;
  endfunction

  function automatic int blink_mask_offset(input int nd);
    return nd + 1;
  endfunction

endpackage

// File: rtl/hex7_seg_decode.sv
// Combinational 4-bit hex value to seven-segment glyph (1 = lit).
// Zero latency.
// No flow control.
module hex7_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  // Table lookup of the glyph for the nibble
  always_comb begin
    seg = HEX_SEG_TABLE[hex];
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller behind a zero-wait-state register slave;
// a register write shows on out_port one clock after the write edge; reads are combinational.
// No backpressure: every access completes in its own cycle. Optional scan outputs: HEX_DISPLAY_SCAN_EN.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1,
  parameter int ADDR_W     = 4
`ifdef HEX_DISPLAY_SCAN_EN
  ,
  parameter int SCAN_DIV   = 50000
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [7:0]                writedata,
  output logic [7:0]                readdata,
  output logic [SEG_W*NUM_DIGITS-1:0] out_port
`ifdef HEX_DISPLAY_SCAN_EN
  ,
  output logic [SEG_W-1:0]          scan_seg,
  output logic [NUM_DIGITS-1:0]     scan_dig
`endif
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_offset(NUM_DIGITS));
  localparam logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(blink_mask_offset(NUM_DIGITS));
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [SEG_W*NUM_DIGITS-1:0] UNLIT_ALL = {(SEG_W*NUM_DIGITS){POL_LOW}};

  logic [NUM_DIGITS-1:0][SEG_W-1:0] digit_q;
  logic [CTRL_W-1:0]                ctrl_q;
  logic [NUM_DIGITS-1:0]            mask_q;
  logic [BLINK_W-1:0]               blink_cnt;
  logic                             blink_phase;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] dec_seg;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_lit;
  logic [SEG_W*NUM_DIGITS-1:0]      pins_next;
  logic                             wr_en;
  logic                             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  // writedata[7] is wider than every register and is intentionally dropped
  assign unused_wdata = writedata[7];

  // Lit-segment pattern to pin level for the configured polarity
  function automatic logic [SEG_W-1:0] to_pins(input logic [SEG_W-1:0] s);
    return POL_LOW ? ~s : s;
  endfunction

  // Register file writes; unmapped addresses simply match nothing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= '0;
      ctrl_q  <= '0;
      mask_q  <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (address == ADDR_W'(k)) digit_q[k] <= writedata[SEG_W-1:0];
      end
      if (address == CTRL_ADDR) ctrl_q <= writedata[CTRL_W-1:0];
      if (address == MASK_ADDR) mask_q <= writedata[NUM_DIGITS-1:0];
    end
  end

  // Zero-wait-state read mux, zero-extended; deselected or unmapped reads return 0
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (address == ADDR_W'(k)) readdata = {1'b0, digit_q[k]};
      end
      if (address == CTRL_ADDR) readdata = {{(8-CTRL_W){1'b0}}, ctrl_q};
      if (address == MASK_ADDR) readdata = 8'(mask_q);
    end
  end

  // Blink timer; held at zero while blink is disabled so enabling starts visible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!ctrl_q[CTRL_BLINK_EN_BIT]) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    hex7_seg_decode u_dec (
      .hex (digit_q[k][3:0]),
      .seg (dec_seg[k])
    );
  end

  // Per-digit composition: decode or raw, blink blanking, then pin polarity
  always_comb begin
    seg_lit   = '0;
    pins_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg_lit[k] = ctrl_q[CTRL_DECODE_BIT] ? dec_seg[k] : digit_q[k];
      if (ctrl_q[CTRL_BLINK_EN_BIT] && mask_q[k] && blink_phase) seg_lit[k] = '0;
      pins_next[SEG_W*k +: SEG_W] = to_pins(seg_lit[k]);
    end
  end

  // Registered segment pins; reset drives every segment unlit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= UNLIT_ALL;
    else          out_port <= pins_next;
  end

`ifdef HEX_DISPLAY_SCAN_EN
  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [NUM_DIGITS-1:0] dig_onehot;

  // Scan timer: advance the active digit every SCAN_DIV cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // One-hot select of the active digit
  always_comb begin
    dig_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_onehot[k] = (scan_idx == IDX_W'(k));
    end
  end

  // Registered scan outputs, same polarity as out_port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_seg <= {SEG_W{POL_LOW}};
      scan_dig <= POL_LOW ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
    end else begin
      scan_seg <= to_pins(seg_lit[scan_idx]);
      scan_dig <= POL_LOW ? ~dig_onehot : dig_onehot;
    end
  end
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (6 digits, active-low, BLINK_DIV=4).
module tb_hex_display_ctrl;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic [41:0] out_port;
  logic [7:0]  rd;

  int tests = 0;
  int fails = 0;

  hex_display_ctrl #(
    .NUM_DIGITS (6),
    .BLINK_DIV  (4),
    .ACTIVE_LOW (1),
    .ADDR_W     (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [41:0] obs, input logic [41:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Bus write; returns 1 ns after the write edge
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rdreg(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out_port, 42'h3FF_FFFF_FFFF);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rdreg(4'(a), rd);
      check("reset_read", 42'(rd), 42'h0);
    end

    // Raw mode
    wr(4'd2, 8'h5B);
    check("raw_latency", 42'(out_port[20:14]), 42'h7F);
    step();
    check("raw_dig2", 42'(out_port[20:14]), 42'h24);
    check("raw_low", 42'(out_port[13:0]), 42'h3FFF);
    check("raw_high", 42'(out_port[41:21]), 42'h1F_FFFF);
    rdreg(4'd2, rd);
    check("raw_read", 42'(rd), 42'h5B);
    address = 4'd2;
    #1;
    check("read_no_cs", 42'(readdata), 42'h0);

    // Decode mode
    wr(4'd6, 8'h01);
    wr(4'd0, 8'h0A);
    wr(4'd1, 8'h8F);
    step();
    check("dec_dig0", 42'(out_port[6:0]), 42'h08);
    check("dec_dig1", 42'(out_port[13:7]), 42'h0E);
    check("dec_dig2", 42'(out_port[20:14]), 42'h03);
    check("dec_dig3", 42'(out_port[27:21]), 42'h40);
    rdreg(4'd1, rd);
    check("dec_read1", 42'(rd), 42'h0F);
    rdreg(4'd6, rd);
    check("ctrl_read", 42'(rd), 42'h01);

    // Unmapped write
    wr(4'd9, 8'hFF);
    step();
    check("unmap_out", out_port, {7'h40, 7'h40, 7'h40, 7'h03, 7'h0E, 7'h08});
    rdreg(4'd9, rd);
    check("unmap_read", 42'(rd), 42'h0);
    rdreg(4'd6, rd);
    check("unmap_ctrl", 42'(rd), 42'h01);
    rdreg(4'd7, rd);
    check("unmap_mask", 42'(rd), 42'h0);

    // Blink on digit 0: 4 visible, 4 blank, repeating
    wr(4'd7, 8'h01);
    rdreg(4'd7, rd);
    check("mask_read", 42'(rd), 42'h01);
    wr(4'd6, 8'h03);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("blink_dig0", 42'(out_port[6:0]), (((i - 1) / 4) % 2 == 1) ? 42'h7F : 42'h08);
      check("blink_dig1", 42'(out_port[13:7]), 42'h0E);
    end

    // Clear BLINK_EN during a blank phase
    wr(4'd6, 8'h01);
    check("unblink_e1", 42'(out_port[6:0]), 42'h7F);
    step();
    check("unblink_e2", 42'(out_port[6:0]), 42'h08);

    // Reset asserted mid-blank
    wr(4'd6, 8'h03);
    repeat (5) step();
    check("preblank", 42'(out_port[6:0]), 42'h7F);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", out_port, 42'h3FF_FFFF_FFFF);
    rdreg(4'd6, rd);
    check("rst_ctrl", 42'(rd), 42'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rdreg(4'd0, rd);
    check("rst_dig0", 42'(rd), 42'h0);

    // Counter restarts from zero after reset
    wr(4'd7, 8'h01);
    wr(4'd6, 8'h03);
    repeat (4) step();
    check("restart_vis", 42'(out_port[6:0]), 42'h40);
    step();
    check("restart_blank", 42'(out_port[6:0]), 42'h7F);
    check("restart_dig1", 42'(out_port[13:7]), 42'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
